dbus_sram_responder: RTL and testbench
======================================

# dbus_sram_responder

Responder end of the data-side SRAM-like bus (`req`/`addr_ok`/`data_ok`) that the execute stage's AGU drives toward the DCache.

- Backs the bus with an on-chip word-addressed memory.
- Accepts up to `DEPTH` outstanding requests and returns them in order after a fixed, programmable latency.
- Used as the DCache stand-in for execute-stage bring-up and verification, and as a tightly-coupled data RAM in small configurations.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: word-index bits; memory holds 2^ADDR_WIDTH 32-bit words.
- `DEPTH`, default 4: maximum outstanding requests (power of two, 2..8).
- `LATENCY`, default 2: cycles from acceptance to `data_ok` (≥1).

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `resetn` in 1: reset, synchronous, active-low.
- `req` in 1: request valid.
- `wr` in 1: 1 = store, 0 = load.
- `wstrb` in 4: byte enables for stores.
- `size` in 3: access size, 0/1/2 = byte/half/word; carried only, not used for masking.
- `addr` in 32: byte address.
- `wdata` in 32: store data.
- `addr_ok` out 1: request accepted this cycle.
- `data_ok` out 1: head response returned this cycle, single-cycle pulse.
- `rdata` out 32: load data, valid with `data_ok`.
- `resp_stall` in 1: verification hook; holds the head response back while high. Tie to 0 in real use.

## Operation
- **Word index and aliasing.** Word index = `addr[ADDR_WIDTH+1:2]`. Upper bits and `addr[1:0]` are ignored, so the memory aliases.
- **Acceptance.** `addr_ok = req && (count < DEPTH)`, where `count` is registered. There is no same-cycle bypass from a retiring head: a full queue refuses even when `data_ok` fires in that cycle.
- **Store acceptance.** On a handshake (`req && addr_ok`) with `wr=1`, memory bytes with `wstrb[i]=1` are written at that edge. A store with `wstrb=0` enqueues but writes nothing.
- **Load acceptance.** On a handshake with `wr=0`, the full word `mem[idx]` is captured into the entry at that edge. Byte/half extraction is the initiator's job.
- **Ordering.** There is at most one request per cycle. Every earlier store is therefore already in memory when a later load captures, which gives store→load ordering for free.
- **Entry contents.** `is_write`, `data[31:0]`, `age`. `age` is `$clog2(LATENCY+1)` bits, saturating at `LATENCY`.
- **Ageing.** An entry has `age=0` in its enqueue cycle. Each valid entry increments `age` every cycle (saturating), including while `resp_stall` is high.
- **Retire.**
  - `data_ok = (count != 0) && head.age == LATENCY && !resp_stall`.
  - `rdata = head.is_write ? 0 : head.data`.
  - On `data_ok`, head advances by 1 (mod `DEPTH`).
- **Responses.** Stores return `data_ok` as well, with `rdata = 0`. Responses are strictly in acceptance order, at most one per cycle.
- **Queue pointers.** Circular buffer with `head` and `tail` pointers of `$clog2(DEPTH)` bits, which wrap naturally, plus `count` of `$clog2(DEPTH)+1` bits.
  - Enqueue and retire in the same cycle: `count` unchanged, both pointers advance.
- **No flush input.** The initiator drains outstanding responses after its own flush. The responder never drops an accepted request.

## Timing
- **Reset values.** Under `!resetn`: `head=tail=count=0`, all `age=0`, `data_ok=0`, `rdata=0`. `addr_ok` is 0 during reset even if `req` is high. Memory contents are not reset.
- **Reset mid-operation.** Discards every outstanding entry. Stores already accepted stay in memory.
- **`addr_ok`.** Combinational from `req` and registered `count`; no path from `data_ok` or `resp_stall`.
- **Latency.** A request accepted in cycle T gives `data_ok` in cycle T+LATENCY, provided the head is not blocked.
- **Throughput.** Back-to-back requests with `LATENCY ≥ 1` and `DEPTH ≥ LATENCY+1` sustain one request per cycle.
- **Fill condition.** With `DEPTH ≤ LATENCY`, the queue fills and `addr_ok` drops to 0 until the head retires.
- **`resp_stall`.**
  - When released, the head retires that cycle if its age is saturated.
  - Subsequent entries follow on consecutive cycles once their ages are saturated.
- **Registered outputs.** `data_ok` and `rdata` are driven from registered queue state; no input→`data_ok` combinational path except `resp_stall`.

## Structure
- **Shared package.** Add `dbus_resp_entry_t` (`is_write`, `data`, `age`) to the shared `cpu.svh` typedefs alongside `uint32_t`; no other new constants.
- **Sub-module `resp_queue`.** Parameterized circular FIFO holding `dbus_resp_entry_t`. It keeps head/tail/count, per-entry ageing and the full/empty flags.
- **Top level.** Keeps the memory array, byte-strobe write and load capture.

## Test plan
- **Write then read.** Reset, store `addr=0x40`, `wdata=0xDEADBEEF`, `wstrb=4'hF`, then load `0x40` → `data_ok` at T+2 with `rdata=0`, then `rdata=0xDEADBEEF` next cycle.
- **Partial strobe.** Store `0x11223344` at `0x8`, then store `0x000000AA` with `wstrb=4'b0001`, then load `0x8` → `rdata=0x112233AA`.
- **Full queue.** `DEPTH=4`, `resp_stall=1`, `req` held for 6 cycles → exactly 4 `addr_ok`, then 0. Release stall → 4 `data_ok` on consecutive cycles, then `addr_ok` resumes.
- **Pointer wrap.** 20 back-to-back loads to distinct words with `LATENCY=2` → one `data_ok` per cycle from T+2, data in order.
- **Simultaneous events and aliasing.** Enqueue and retire in the same cycle at `count=3` → `count` stays 3. Address `0x1000` aliases to `0x0` when `ADDR_WIDTH=10`.
- **Reset mid-operation.** Reset with 3 outstanding → no `data_ok` after reset; earlier stores readable afterwards.

Source files
------------

// File: rtl/dbus_sram_responder_pkg.sv
// Shared typedefs for the data-side SRAM-like bus responder.
// Queue entries carry the captured load word; ageing lives in the queue.
package dbus_sram_responder_pkg;

  typedef logic [31:0] uint32_t;

  typedef struct packed {
    logic    is_write;
    uint32_t data;
  } dbus_resp_entry_t;

endpackage

// File: rtl/dbus_sram_responder_resp_queue.sv
// In-order response FIFO with per-entry saturating age.
// Head retires once its age reaches LATENCY and the stall hook is low.
module resp_queue
  import dbus_sram_responder_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  dbus_resp_entry_t push_entry,
  input  logic             stall,
  output logic             pop,
  output logic             full,
  output logic             empty,
  output dbus_resp_entry_t head_entry
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int AW = $clog2(LATENCY + 1);
  localparam logic [AW-1:0] AGE_MAX = AW'(LATENCY);

  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] vld;
  logic [AW-1:0]    age [DEPTH];
  dbus_resp_entry_t ent [DEPTH];

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign head_entry = ent[head];
  assign pop        = !empty && (age[head] == AGE_MAX) && !stall;

  always_ff @(posedge clk) begin
    if (push) begin
      ent[tail] <= push_entry;
    end
  end

  // The acceptance cycle itself counts as age 0, so the entry lands at 1.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      vld   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (PW'(i) == tail)) begin
          age[i] <= AW'(1);
        end else if (vld[i] && (age[i] != AGE_MAX)) begin
          age[i] <= age[i] + AW'(1);
        end
      end
      if (pop) begin
        vld[head] <= 1'b0;
        head      <= head + PW'(1);
      end
      if (push) begin
        vld[tail] <= 1'b1;
        tail      <= tail + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dbus_sram_responder.sv
// Word-addressed SRAM behind the data-side req/addr_ok/data_ok bus.
// Stores write at acceptance; loads capture the word at acceptance.
module dbus_sram_responder
  import dbus_sram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 4,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [3:0]  wstrb,
  input  logic [2:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  input  logic        resp_stall
);

  uint32_t mem [2**ADDR_WIDTH];

  logic [ADDR_WIDTH-1:0] idx;
  logic                  full;
  logic                  empty;
  dbus_resp_entry_t      push_entry;
  dbus_resp_entry_t      head_entry;
  logic                  unused_ok;

  assign idx       = addr[ADDR_WIDTH+1:2];
  assign unused_ok = ^{size, addr[31:ADDR_WIDTH+2], addr[1:0]};
  assign addr_ok   = req && resetn && !full;

  assign push_entry.is_write = wr;
  assign push_entry.data     = wr ? '0 : mem[idx];

  always_ff @(posedge clk) begin
    if (addr_ok && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  resp_queue #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) u_queue (
    .clk        (clk),
    .resetn     (resetn),
    .push       (addr_ok),
    .push_entry (push_entry),
    .stall      (resp_stall),
    .pop        (data_ok),
    .full       (full),
    .empty      (empty),
    .head_entry (head_entry)
  );

  assign rdata = (!empty && !head_entry.is_write)
               ? head_entry.data : '0;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Scoreboard bench for dbus_sram_responder: driver pushes expectations,
// a negedge monitor pops and checks them on every data_ok.
module tb_dbus_sram_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req;
  logic        wr;
  logic [3:0]  wstrb;
  logic [2:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        resp_stall;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] d;
    int          due;
    bit          exact;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  dbus_sram_responder #(
    .ADDR_WIDTH (10),
    .DEPTH      (4),
    .LATENCY    (LAT)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req        (req),
    .wr         (wr),
    .wstrb      (wstrb),
    .size       (size),
    .addr       (addr),
    .wdata      (wdata),
    .addr_ok    (addr_ok),
    .data_ok    (data_ok),
    .rdata      (rdata),
    .resp_stall (resp_stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (resetn === 1'b1 && data_ok === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_data_ok: got 1 expected 0 (cycle %0d)",
                 cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("rdata", rdata, mon_e.d);
        if (mon_e.exact) chk("latency", 32'(cyc), 32'(mon_e.due));
      end
    end
  end

  task automatic push_exp(input logic [31:0] d, input bit exact);
    exp_t e;
    e.d     = d;
    e.due   = cyc + LAT;
    e.exact = exact;
    sb.push_back(e);
  endtask

  task automatic issue(input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] e, input bit exact);
    int n = 0;
    @(posedge clk) #1;
    req = 1'b1; wr = w; addr = a; wdata = d; wstrb = s;
    forever begin
      @(negedge clk);
      if (addr_ok) begin
        push_exp(e, exact);
        return;
      end
      n++;
      if (n > 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: got addr_ok=0 expected 1");
        return;
      end
      @(posedge clk) #1;
    end
  endtask

  task automatic idle();
    @(posedge clk) #1;
    req = 1'b0; wr = 1'b0; wstrb = 4'h0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0; req = 1'b1; wr = 1'b0; wstrb = 4'h0;
    size = 3'd2; addr = 32'h0; wdata = 32'h0; resp_stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_addr_ok", {31'b0, addr_ok}, 32'h0);
    chk("reset_data_ok", {31'b0, data_ok}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    @(posedge clk) #1;
    resetn = 1'b1; req = 1'b0;

    // write then read
    issue(1, 32'h40, 32'hDEADBEEF, 4'hF, 32'h0, 1);
    issue(0, 32'h40, 32'h0, 4'h0, 32'hDEADBEEF, 1);
    idle();
    drain();

    // partial strobes and an empty strobe
    issue(1, 32'h8, 32'h11223344, 4'hF, 32'h0, 1);
    issue(1, 32'h8, 32'h000000AA, 4'b0001, 32'h0, 1);
    issue(0, 32'h8, 32'h0, 4'h0, 32'h112233AA, 1);
    issue(1, 32'h8, 32'hFFFFFFFF, 4'h0, 32'h0, 1);
    issue(0, 32'h8, 32'h0, 4'h0, 32'h112233AA, 1);
    idle();
    drain();

    // aliasing: upper bits and byte offset ignored
    issue(1, 32'h1000, 32'hCAFEF00D, 4'hF, 32'h0, 1);
    issue(0, 32'h0, 32'h0, 4'h0, 32'hCAFEF00D, 1);
    issue(0, 32'h1003, 32'h0, 4'h0, 32'hCAFEF00D, 1);
    idle();
    drain();

    // back-to-back stores then loads across pointer wrap
    for (int i = 0; i < 20; i++)
      issue(1, 32'h200 + 32'(4*i), 32'hA5A50000 + 32'(i),
            4'hF, 32'h0, 1);
    for (int i = 0; i < 20; i++)
      issue(0, 32'h200 + 32'(4*i), 32'h0, 4'h0,
            32'hA5A50000 + 32'(i), 1);
    idle();
    drain();

    // full queue under stall
    begin
      int acc = 0;
      @(posedge clk) #1;
      resp_stall = 1'b1;
      for (int i = 0; i < 6; i++) begin
        req = 1'b1; wr = 1'b0; addr = 32'h200 + 32'(4*i);
        @(negedge clk);
        if (addr_ok) begin
          acc++;
          push_exp(32'hA5A50000 + 32'(i), 0);
        end
        @(posedge clk) #1;
      end
      chk("full_accept_count", 32'(acc), 32'd4);
      req = 1'b0; resp_stall = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk("release_data_ok", {31'b0, data_ok}, 32'h1);
      end
      @(negedge clk);
      chk("after_release_data_ok", {31'b0, data_ok}, 32'h0);
      @(posedge clk) #1;
      req = 1'b1; addr = 32'h240;
      @(negedge clk);
      chk("addr_ok_resumes", {31'b0, addr_ok}, 32'h1);
      if (addr_ok) push_exp(32'hA5A50010, 1);
      idle();
      drain();
    end

    // enqueue and retire together at count 3
    @(posedge clk) #1;
    resp_stall = 1'b1;
    issue(0, 32'h200, 32'h0, 4'h0, 32'hA5A50000, 0);
    issue(0, 32'h204, 32'h0, 4'h0, 32'hA5A50001, 0);
    issue(0, 32'h208, 32'h0, 4'h0, 32'hA5A50002, 0);
    @(posedge clk) #1;
    resp_stall = 1'b0; addr = 32'h20C;
    @(negedge clk);
    chk("simul_data_ok", {31'b0, data_ok}, 32'h1);
    chk("simul_addr_ok", {31'b0, addr_ok}, 32'h1);
    if (addr_ok) push_exp(32'hA5A50003, 0);
    @(posedge clk) #1;
    addr = 32'h210;
    @(negedge clk);
    chk("count_held_addr_ok", {31'b0, addr_ok}, 32'h1);
    if (addr_ok) push_exp(32'hA5A50004, 0);
    idle();
    drain();

    // reset with three outstanding
    @(posedge clk) #1;
    resp_stall = 1'b1;
    issue(1, 32'h80, 32'h5A5A5A5A, 4'hF, 32'h0, 0);
    issue(0, 32'h40, 32'h0, 4'h0, 32'hDEADBEEF, 0);
    issue(0, 32'h8, 32'h0, 4'h0, 32'h112233AA, 0);
    @(posedge clk) #1;
    req = 1'b0; resetn = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1; resp_stall = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("no_data_ok_after_reset", {31'b0, data_ok}, 32'h0);
    end
    issue(0, 32'h80, 32'h0, 4'h0, 32'h5A5A5A5A, 1);
    issue(0, 32'h40, 32'h0, 4'h0, 32'hDEADBEEF, 1);
    idle();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
